// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the two execute issue ports and the shared ALU.
// Requesters drive op/operands/tag with valid; the ALU side returns ready and a held result.
// The slave side is the arbiter and the master side is the issue/writeback logic.
interface alu_share_arb_if #(
    parameter int TAG_W = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [31:0]      req0_op1;
    logic [31:0]      req0_op2;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [31:0]      req1_op1;
    logic [31:0]      req1_op2;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_data;

    modport slave (
        input  req0_valid, req0_op, req0_op1, req0_op2, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_op1, req1_op2, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_data,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_op1, req0_op2, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_op1, req1_op2, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_data,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin shares one ALU between two requesters, one registered result slot.
// Latency: 1 cycle for non-MUL ops, MUL_LAT+1 cycles for MUL.
// Backpressure: result held while rsp_ready=0; new accepts only when the slot is free or draining.
module alu_share_arb #(
    parameter int TAG_W   = 5,
    parameter int MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           flush,
    output logic           busy,
    alu_share_arb_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_OP2 = 4'd9;

    localparam bit         MUL_MULTI = (MUL_LAT > 0);
    localparam logic [3:0] CNT_INIT  = (MUL_LAT > 0) ? 4'(MUL_LAT - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;

    state_t           state;
    logic             last_grant;
    logic [3:0]       cnt;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;

    logic             window;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [3:0]       sel_op;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      alu_res;

    // resetn gates the window so both readies read 0 while reset is held.
    always_comb begin
        window = resetn && !flush &&
                 (state == S_IDLE || (state == S_OUT && bus.rsp_ready));
        grant0 = window && bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = window && bus.req1_valid && (!bus.req0_valid || !last_grant);
        accept = grant0 || grant1;
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        sel_op  = grant1 ? bus.req1_op  : bus.req0_op;
        sel_a   = grant1 ? bus.req1_op1 : bus.req0_op1;
        sel_b   = grant1 ? bus.req1_op2 : bus.req0_op2;
        sel_tag = grant1 ? bus.req1_tag : bus.req0_tag;
        alu_res = '0;
        case (sel_op)
            OP_ADD:  alu_res = sel_a + sel_b;
            OP_SUB:  alu_res = sel_a - sel_b;
            OP_SLT:  alu_res = {31'd0, $signed(sel_a) < $signed(sel_b)};
            OP_AND:  alu_res = sel_a & sel_b;
            OP_OR:   alu_res = sel_a | sel_b;
            OP_XOR:  alu_res = sel_a ^ sel_b;
            OP_SLL:  alu_res = sel_a << sel_b[4:0];
            OP_SRL:  alu_res = sel_a >> sel_b[4:0];
            OP_MUL:  alu_res = sel_a * sel_b;
            OP_OP2:  alu_res = sel_b;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            last_grant   <= 1'b1;
            cnt          <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            busy         <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_tag   <= '0;
            bus.rsp_data  <= '0;
        end else if (flush) begin
            state         <= S_IDLE;
            cnt           <= '0;
            busy          <= 1'b0;
            bus.rsp_valid <= 1'b0;
        end else begin
            case (state)
                S_MUL: begin
                    if (cnt == 4'd0) begin
                        // Low 32 bits of a product are the same signed or unsigned.
                        bus.rsp_data  <= mul_a * mul_b;
                        bus.rsp_valid <= 1'b1;
                        state         <= S_OUT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        last_grant  <= grant1;
                        bus.rsp_id  <= grant1;
                        bus.rsp_tag <= sel_tag;
                        busy        <= 1'b1;
                        if (MUL_MULTI && sel_op == OP_MUL) begin
                            mul_a         <= sel_a;
                            mul_b         <= sel_b;
                            cnt           <= CNT_INIT;
                            bus.rsp_valid <= 1'b0;
                            state         <= S_MUL;
                        end else begin
                            bus.rsp_data  <= alu_res;
                            bus.rsp_valid <= 1'b1;
                            state         <= S_OUT;
                        end
                    end else if (state != S_OUT || bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Scenario bench for alu_share_arb: expected results are queued at grant time
// and popped when the result handshake completes.
module tb_alu_share_arb;
    localparam int TAG_W   = 5;
    localparam int MUL_LAT = 2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_OP2 = 4'd9;

    typedef struct packed {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;
    logic busy;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic lg_model;

    alu_share_arb_if #(.TAG_W(TAG_W)) bus ();

    alu_share_arb #(.TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_MUL:  return p[31:0];
            OP_OP2:  return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t);
        bus.req0_op  = op;
        bus.req0_op1 = a;
        bus.req0_op2 = b;
        bus.req0_tag = t;
    endtask

    task automatic drive1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t);
        bus.req1_op  = op;
        bus.req1_op1 = a;
        bus.req1_op2 = b;
        bus.req1_tag = t;
    endtask

    task automatic test_reset;
        resetn         = 1'b0;
        flush          = 1'b0;
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        drive0(OP_ADD, 32'd1, 32'd2, '0);
        drive1(OP_ADD, 32'd0, 32'd0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_id, busy,
             bus.req0_ready, bus.req1_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b data=%h tag=%0d id=%b busy=%b rdy0=%b rdy1=%b, all must be 0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_id, busy,
                     bus.req0_ready, bus.req1_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        resetn         = 1'b1;
        lg_model       = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.rsp_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release: valid=%b busy=%b, required 0 0", bus.rsp_valid, busy);
        end
        tick();
    endtask

    task automatic test_single_add;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        drive0(OP_ADD, 32'h7FFF_FFFF, 32'h1, TAG_W'(3));
        @(negedge clk);
        n_cmp++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL add_grant: rdy0=%b rdy1=%b, required 1 0", bus.req0_ready, bus.req1_ready);
        end
        exp_q.push_back({1'b0, TAG_W'(3), ref_alu(OP_ADD, 32'h7FFF_FFFF, 32'h1)});
        lg_model = 1'b0;
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL add_result: valid=%b data=%h, required 1 80000000", bus.rsp_valid, bus.rsp_data);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL add_rsp: unexpected result data=%h", bus.rsp_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== e) begin
                    n_err++;
                    $display("FAIL add_rsp: got id=%b tag=%0d data=%h, expected id=%b tag=%0d data=%h",
                             bus.rsp_id, bus.rsp_tag, bus.rsp_data, e.id, e.tag, e.data);
                end
            end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops0 [4];
        logic [3:0]  ops1 [4];
        logic [31:0] a0 [4];
        logic [31:0] b0 [4];
        logic [31:0] a1 [4];
        logic [31:0] b1 [4];
        int   i0  = 0;
        int   i1  = 0;
        int   cyc = 0;
        logic g0;
        logic g1;
        ops0 = '{OP_ADD, OP_SUB, OP_AND, OP_XOR};
        ops1 = '{OP_OR, OP_SLT, OP_SLL, OP_SUB};
        for (int k = 0; k < 4; k++) begin
            a0[k] = $urandom;
            b0[k] = $urandom;
            a1[k] = $urandom;
            b1[k] = $urandom;
        end
        bus.rsp_ready = 1'b1;
        while ((i0 < 4 || i1 < 4 || exp_q.size() > 0) && cyc < 40) begin
            bus.req0_valid = (i0 < 4);
            bus.req1_valid = (i1 < 4);
            if (i0 < 4) drive0(ops0[i0], a0[i0], b0[i0], TAG_W'(10 + i0));
            if (i1 < 4) drive1(ops1[i1], a1[i1], b1[i1], TAG_W'(20 + i1));
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rr_rsp: unexpected result id=%b data=%h", bus.rsp_id, bus.rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== e) begin
                        n_err++;
                        $display("FAIL rr_rsp: got id=%b tag=%0d data=%h, expected id=%b tag=%0d data=%h",
                                 bus.rsp_id, bus.rsp_tag, bus.rsp_data, e.id, e.tag, e.data);
                    end
                end
            end
            g0 = bus.req0_valid && (!bus.req1_valid || lg_model);
            g1 = bus.req1_valid && !g0;
            n_cmp++;
            if ({bus.req1_ready, bus.req0_ready} !== {g1, g0}) begin
                n_err++;
                $display("FAIL rr_grant: rdy1/rdy0=%b%b, required %b%b", bus.req1_ready,
                         bus.req0_ready, g1, g0);
            end
            if (g0) begin
                exp_q.push_back({1'b0, TAG_W'(10 + i0), ref_alu(ops0[i0], a0[i0], b0[i0])});
                i0++;
                lg_model = 1'b0;
            end else if (g1) begin
                exp_q.push_back({1'b1, TAG_W'(20 + i1), ref_alu(ops1[i1], a1[i1], b1[i1])});
                i1++;
                lg_model = 1'b1;
            end
            tick();
            cyc++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n_cmp++;
        if (cyc != 9) begin
            n_err++;
            $display("FAIL rr_throughput: took %0d cycles, required 9", cyc);
        end
    endtask

    task automatic test_mul;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        drive1(OP_MUL, 32'hFFFF_FFFE, 32'd3, TAG_W'(7));
        @(negedge clk);
        n_cmp++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL mul_grant: rdy0=%b rdy1=%b, required 0 1", bus.req0_ready, bus.req1_ready);
        end
        exp_q.push_back({1'b1, TAG_W'(7), ref_alu(OP_MUL, 32'hFFFF_FFFE, 32'd3)});
        lg_model = 1'b1;
        tick();
        bus.req0_valid = 1'b1;
        drive0(OP_ADD, 32'd100, 32'd23, TAG_W'(5));
        for (int k = 1; k <= MUL_LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 4'b1000) begin
                n_err++;
                $display("FAIL mul_busy: cycle %0d busy=%b rdy0=%b rdy1=%b valid=%b, required 1 0 0 0",
                         k, busy, bus.req0_ready, bus.req1_ready, bus.rsp_valid);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hFFFF_FFFA) begin
            n_err++;
            $display("FAIL mul_result: valid=%b data=%h, required 1 fffffffa", bus.rsp_valid, bus.rsp_data);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL mul_rsp: unexpected result data=%h", bus.rsp_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== e) begin
                    n_err++;
                    $display("FAIL mul_rsp: got id=%b tag=%0d data=%h, expected id=%b tag=%0d data=%h",
                             bus.rsp_id, bus.rsp_tag, bus.rsp_data, e.id, e.tag, e.data);
                end
            end
        end
        n_cmp++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL mul_pass_grant: rdy0=%b rdy1=%b, required 1 0", bus.req0_ready, bus.req1_ready);
        end
        exp_q.push_back({1'b0, TAG_W'(5), ref_alu(OP_ADD, 32'd100, 32'd23)});
        lg_model = 1'b0;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL mul_next_rsp: unexpected result data=%h", bus.rsp_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== e) begin
                    n_err++;
                    $display("FAIL mul_next_rsp: got id=%b tag=%0d data=%h, expected id=%b tag=%0d data=%h",
                             bus.rsp_id, bus.rsp_tag, bus.rsp_data, e.id, e.tag, e.data);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL mul_drain: %0d results missing, required 0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    task automatic test_hold;
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        drive0(OP_SLT, 32'hFFFF_FFFF, 32'd1, TAG_W'(9));
        @(negedge clk);
        n_cmp++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL hold_grant: rdy0=%b rdy1=%b, required 1 0", bus.req0_ready, bus.req1_ready);
        end
        exp_q.push_back({1'b0, TAG_W'(9), ref_alu(OP_SLT, 32'hFFFF_FFFF, 32'd1)});
        lg_model = 1'b0;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        drive1(OP_ADD, 32'd5, 32'd6, TAG_W'(2));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_id, bus.req0_ready,
                 bus.req1_ready} !== {1'b1, 32'd1, TAG_W'(9), 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL hold_stable: cycle %0d valid=%b data=%h tag=%0d id=%b rdy0=%b rdy1=%b, required 1 00000001 9 0 0 0",
                         k, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_id,
                         bus.req0_ready, bus.req1_ready);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL hold_rsp: unexpected result data=%h", bus.rsp_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== e) begin
                    n_err++;
                    $display("FAIL hold_rsp: got id=%b tag=%0d data=%h, expected id=%b tag=%0d data=%h",
                             bus.rsp_id, bus.rsp_tag, bus.rsp_data, e.id, e.tag, e.data);
                end
            end
        end
        n_cmp++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_release_grant: rdy0=%b rdy1=%b, required 0 1", bus.req0_ready, bus.req1_ready);
        end
        exp_q.push_back({1'b1, TAG_W'(2), ref_alu(OP_ADD, 32'd5, 32'd6)});
        lg_model = 1'b1;
        tick();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL hold_next_rsp: unexpected result data=%h", bus.rsp_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== e) begin
                    n_err++;
                    $display("FAIL hold_next_rsp: got id=%b tag=%0d data=%h, expected id=%b tag=%0d data=%h",
                             bus.rsp_id, bus.rsp_tag, bus.rsp_data, e.id, e.tag, e.data);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL hold_drain: %0d results missing, required 0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    task automatic test_abort(input bit use_reset);
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        drive0(OP_MUL, 32'd6, 32'd7, TAG_W'(4));
        @(negedge clk);
        n_cmp++;
        if (bus.req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_mul_grant: rdy0=%b, required 1", bus.req0_ready);
        end
        lg_model = 1'b0;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        drive1(OP_ADD, 32'd1, 32'd2, TAG_W'(12));
        @(negedge clk);
        n_cmp++;
        if ({busy, bus.req0_ready, bus.req1_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL abort_in_mul: busy=%b rdy0=%b rdy1=%b, required 1 0 0", busy,
                     bus.req0_ready, bus.req1_ready);
        end
        tick();
        if (use_reset) resetn = 1'b0;
        else flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (use_reset) begin
            if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_id, busy,
                 bus.req0_ready, bus.req1_ready} !== '0) begin
                n_err++;
                $display("FAIL abort_reset_outputs: valid=%b data=%h tag=%0d id=%b busy=%b rdy0=%b rdy1=%b, all must be 0",
                         bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_id, busy,
                         bus.req0_ready, bus.req1_ready);
            end
        end else if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_flush_cycle: valid=%b rdy0=%b rdy1=%b, required 0 0 0",
                     bus.rsp_valid, bus.req0_ready, bus.req1_ready);
        end
        tick();
        flush  = 1'b0;
        resetn = 1'b1;
        if (use_reset) lg_model = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL abort_next_accept: valid=%b rdy0=%b rdy1=%b, required 0 0 1 (reset=%0d)",
                     bus.rsp_valid, bus.req0_ready, bus.req1_ready, use_reset);
        end
        exp_q.push_back({1'b1, TAG_W'(12), ref_alu(OP_ADD, 32'd1, 32'd2)});
        lg_model = 1'b1;
        tick();
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL abort_rsp: unexpected result id=%b tag=%0d data=%h (reset=%0d)",
                             bus.rsp_id, bus.rsp_tag, bus.rsp_data, use_reset);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== e) begin
                        n_err++;
                        $display("FAIL abort_rsp: got id=%b tag=%0d data=%h, expected id=%b tag=%0d data=%h",
                                 bus.rsp_id, bus.rsp_tag, bus.rsp_data, e.id, e.tag, e.data);
                    end
                end
            end
            tick();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL abort_drain: %0d results missing, required 0 (reset=%0d)", exp_q.size(), use_reset);
            exp_q.delete();
        end
    endtask

    task automatic test_special_ops;
        logic [3:0]  ops [3];
        logic [31:0] a [3];
        logic [31:0] b [3];
        logic [31:0] want [3];
        int          got = 0;
        ops  = '{OP_SRL, 4'hF, OP_OP2};
        a    = '{32'h8000_0000, 32'h0000_1234, 32'hDEAD_BEEF};
        b    = '{32'd33, 32'h0000_5678, 32'h1234_5000};
        want = '{32'h4000_0000, 32'h0, 32'h1234_5000};
        bus.rsp_ready  = 1'b1;
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.req0_valid = (k < 3);
            if (k < 3) drive0(ops[k], a[k], b[k], TAG_W'(k + 1));
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL special_rsp: unexpected result data=%h", bus.rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== e) begin
                        n_err++;
                        $display("FAIL special_rsp: got id=%b tag=%0d data=%h, expected id=%b tag=%0d data=%h",
                                 bus.rsp_id, bus.rsp_tag, bus.rsp_data, e.id, e.tag, e.data);
                    end
                end
                if (got < 3) begin
                    n_cmp++;
                    if (bus.rsp_data !== want[got]) begin
                        n_err++;
                        $display("FAIL special_value %0d: data=%h, required %h", got, bus.rsp_data, want[got]);
                    end
                end
                got++;
            end
            if (k < 3) begin
                n_cmp++;
                if (bus.req0_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL special_grant %0d: rdy0=%b, required 1", k, bus.req0_ready);
                end
                exp_q.push_back({1'b0, TAG_W'(k + 1), ref_alu(ops[k], a[k], b[k])});
                lg_model = 1'b0;
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        n_cmp++;
        if (got != 3) begin
            n_err++;
            $display("FAIL special_count: %0d results, required 3", got);
            exp_q.delete();
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        lg_model       = 1'b1;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_mul();
        test_hold();
        test_abort(1'b0);
        test_abort(1'b1);
        test_special_ops();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
